// File: rtl/in_port.sv
// Ten-input switch front end: two-flop synchronizers, per-bit debounce counters,
// a debounced active-high level word and sticky press (rising-edge) flags.
module in_port #(
  parameter int DEBOUNCE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  raw_in,
  input  logic        in_read,
  output logic [15:0] in_out,
  output logic [9:0]  edge_out,
  output logic        edge_pending
);

  localparam logic [9:0] LAST = 10'(DEBOUNCE - 1);

  logic [9:0] sync1;
  logic [9:0] sync2;
  logic [9:0] sync;
  logic [9:0] stable;
  logic [9:0] stable_next;
  logic [9:0] rise;
  logic [9:0] cnt      [10];
  logic [9:0] cnt_next [10];

  // Pins are active-low; invert after the synchronizer so everything downstream is active-high.
  assign sync = ~sync2;

  always_comb begin
    stable_next = stable;
    rise        = '0;
    for (int i = 0; i < 10; i++) begin
      cnt_next[i] = cnt[i];
      if (sync[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == LAST) begin
        stable_next[i] = sync[i];
        cnt_next[i]    = '0;
        rise[i]        = sync[i];
      end else begin
        cnt_next[i] = cnt[i] + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '0;
      edge_out <= '0;
      for (int i = 0; i < 10; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= raw_in;
      sync2  <= sync1;
      stable <= stable_next;
      // A press landing on the same edge as a read survives the clear.
      edge_out <= (in_read ? 10'd0 : edge_out) | rise;
      for (int i = 0; i < 10; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign in_out       = {6'b0, stable};
  assign edge_pending = |edge_out;

endmodule

// File: tb/tb_in_port.sv
// Bench for in_port (DEBOUNCE=4): directed scenarios followed by random switch
// activity, every cycle compared against a sliding-window reference model.
module tb_in_port;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [9:0]  raw_in;
  logic        in_read;
  logic [15:0] in_out;
  logic [9:0]  edge_out;
  logic        edge_pending;

  int n_checks = 0;
  int n_fail   = 0;

  in_port #(.DEBOUNCE(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .in_read      (in_read),
    .in_out       (in_out),
    .edge_out     (edge_out),
    .edge_pending (edge_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pin values are seen two edges late; a stable bit flips
  // once the last D seen samples all disagree with it
  logic [9:0]  pin_q[$];
  logic [9:0]  seen_q[$];
  logic [9:0]  m_stable;
  logic [9:0]  m_flags;
  logic [19:0] exp_q[$];

  function automatic void model_reset();
    pin_q    = {10'h3FF, 10'h3FF};
    seen_q   = {};
    m_stable = '0;
    m_flags  = '0;
  endfunction

  function automatic void model_edge(input logic [9:0] raw, input logic rd, input logic rst_n);
    logic [9:0] seen;
    logic [9:0] rise;
    logic       all_diff;
    rise = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      seen = ~pin_q.pop_front();
      pin_q.push_back(raw);
      seen_q.push_back(seen);
      if (seen_q.size() > D) void'(seen_q.pop_front());
      for (int i = 0; i < 10; i++) begin
        all_diff = (seen_q.size() == D);
        for (int k = 0; k < seen_q.size(); k++)
          if (seen_q[k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i]) rise[i] = 1'b1;
        end
      end
      m_flags = (rd ? 10'd0 : m_flags) | rise;
    end
    exp_q.push_back({m_flags, m_stable});
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [19:0] e;
    e = exp_q.pop_front();
    check("in_out",       in_out,                 {6'b0, e[9:0]});
    check("edge_out",     {6'b0, edge_out},       {6'b0, e[19:10]});
    check("edge_pending", {15'b0, edge_pending},  {15'b0, |e[19:10]});
  endtask

  // drivers: inputs change #1 after an edge, outputs are sampled #1 after the next edge
  task automatic tick(input logic [9:0] raw, input logic rd);
    raw_in  = raw;
    in_read = rd;
    model_edge(raw, rd, reset);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("in_out_in_reset",   in_out,            16'h0000);
    check("edge_out_in_reset", {6'b0, edge_out},  16'h0000);
  endtask

  logic [9:0] cur;
  logic [9:0] b;

  initial begin
    reset   = 1'b0;
    raw_in  = 10'h3FF;
    in_read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_in_out", in_out, 16'h0000);
    repeat (3) tick(10'h3FF, 1'b0);
    reset = 1'b1;

    // released inputs after reset: nothing appears
    repeat (20) tick(10'h3FF, 1'b0);
    check("idle_in_out",  in_out,                 16'h0000);
    check("idle_pending", {15'b0, edge_pending},  16'h0000);

    // clean press of bit 0: visible exactly 6 edges later
    repeat (5) tick(10'h3FE, 1'b0);
    check("press0_early", in_out, 16'h0000);
    tick(10'h3FE, 1'b0);
    check("press0_in_out", in_out,            16'h0001);
    check("press0_edge",   {6'b0, edge_out},  16'h0001);
    tick(10'h3FE, 1'b1);
    check("read0_edge",   {6'b0, edge_out},  16'h0000);
    check("read0_in_out", in_out,            16'h0001);
    tick(10'h3FE, 1'b1);

    // 3-cycle glitch on bit 5 is filtered; 5-cycle pulse gets through
    repeat (3) tick(10'h3DE, 1'b0);
    repeat (8) tick(10'h3FE, 1'b0);
    check("glitch5_in_out", in_out,            16'h0001);
    check("glitch5_edge",   {6'b0, edge_out},  16'h0000);
    repeat (5) tick(10'h3DE, 1'b0);
    tick(10'h3FE, 1'b0);
    check("pulse5_in_out", in_out, 16'h0021);
    repeat (6) tick(10'h3FE, 1'b0);
    check("pulse5_release", in_out, 16'h0001);
    tick(10'h3FE, 1'b1);

    // bit 2 flagged, then read coincides with bit 7 debouncing high
    repeat (6) tick(10'h3FA, 1'b0);
    check("flag2_edge", {6'b0, edge_out}, 16'h0004);
    repeat (5) tick(10'h37A, 1'b0);
    tick(10'h37A, 1'b1);
    check("read_vs_new_edge", {6'b0, edge_out}, 16'h0080);

    // release everything, clear flags
    repeat (8) tick(10'h3FF, 1'b0);
    tick(10'h3FF, 1'b1);
    check("all_released", in_out, 16'h0000);

    // bit 9 pressed, reset mid-count, held through release
    repeat (4) tick(10'h1FF, 1'b0);
    assert_reset();
    repeat (2) tick(10'h1FF, 1'b0);
    reset = 1'b1;
    repeat (5) tick(10'h1FF, 1'b0);
    check("rst9_early", in_out, 16'h0000);
    tick(10'h1FF, 1'b0);
    check("rst9_in_out", in_out,            16'h0200);
    check("rst9_edge",   {6'b0, edge_out},  16'h0200);

    // all ten pressed together
    repeat (8) tick(10'h3FF, 1'b0);
    tick(10'h3FF, 1'b1);
    repeat (6) tick(10'h000, 1'b0);
    check("all_in_out", in_out,            16'h03FF);
    check("all_edge",   {6'b0, edge_out},  16'h03FF);

    // random bouncing switches, random reads, occasional resets
    cur = 10'h000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        assert_reset();
        repeat ($urandom_range(1, 3)) tick(cur, 1'b0);
        reset = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        b = 10'd1 << $urandom_range(0, 9);
        cur = cur ^ b;
      end
      tick(cur, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/in_port.md
IN_PORT -- requirements
Module: in_port

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 16, the number of consecutive clk cycles a synchronized input must differ from its stable value before the stable value updates; legal range 2..1023.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port raw_in, input, 10, switch pins, active-low (0 = pressed), already ordered bit 0..9.
REQ-005 SHALL have port in_read, input, 1, controller strobe: edge flags are consumed this cycle.
REQ-006 SHALL have port in_out, output, 16, debounced active-high level, {6'b0, stable[9:0]}.
REQ-007 SHALL have port edge_out, output, 10, sticky rising-edge (press) flags.
REQ-008 SHALL have port edge_pending, output, 1, OR of edge_out.

Function
REQ-009 SHALL pass each raw_in bit through a two-flop synchronizer; sync value = ~second flop, giving active-high.
REQ-010 SHALL keep one counter per bit, width 10, independent of other bits.
REQ-011 Counter behaviour: sync == stable -> counter cleared to 0; sync != stable and counter < DEBOUNCE-1 -> counter +1; sync != stable and counter == DEBOUNCE-1 -> stable <= sync, counter <= 0.
REQ-012 A glitch shorter than DEBOUNCE cycles SHALL NOT change stable; any cycle where sync returns to stable SHALL restart the count from 0.
REQ-013 Latency raw_in change -> in_out change SHALL be exactly DEBOUNCE+2 clk cycles for a clean step (2 synchronizer + DEBOUNCE count).
REQ-014 When stable bit i transitions 0->1, edge_out[i] SHALL be set on the same clock edge that updates stable; a 1->0 transition SHALL NOT set any flag.
REQ-015 edge_out bits SHALL be sticky until consumed; further presses on an already-set bit SHALL leave it 1 (no count).
REQ-016 On a clock edge with in_read=1, every edge_out bit SHALL be cleared except bits receiving a new rising edge on that same edge, which SHALL end up 1 (new event wins over clear).
REQ-017 in_read with no flags set SHALL have no effect; in_read SHALL NOT affect in_out or the counters.
REQ-018 in_out[15:10] SHALL always be 0; edge_pending SHALL be combinational from the registered edge_out.
REQ-019 Counters SHALL never wrap; the maximum value held is DEBOUNCE-1.

Reset
REQ-020 While reset=0: synchronizer flops = 1 (released), stable = 0, counters = 0, edge_out = 0; thus in_out = 16'h0000 and edge_pending = 0.
REQ-021 Reset assertion mid-debounce SHALL discard the partial count; on release, a held-pressed input SHALL take DEBOUNCE+2 cycles to appear and SHALL set its edge flag.
REQ-022 Release of reset SHALL NOT by itself produce an edge flag for released inputs.

Verification (DEBOUNCE=4)
REQ-023 Reset, raw_in=10'h3FF -> in_out=16'h0000, edge_out=0, edge_pending=0 for 20 cycles.
REQ-024 raw_in[0] 1->0 held -> in_out=16'h0001 and edge_out=10'h001 exactly 6 cycles later, edge_pending=1; pulse in_read -> edge_out=0 next cycle, in_out stays 16'h0001.
REQ-025 raw_in[5] low for 3 cycles then high -> in_out and edge_out unchanged throughout; repeat with 5-cycle low pulse -> in_out[5] rises to 1, then falls after release.
REQ-026 Bit 2 flagged; in_read asserted on the exact edge bit 7 debounces high -> edge_out=10'h080 afterwards.
REQ-027 raw_in[9] pressed, reset pulsed low at counter=2, held pressed -> in_out=0 during reset, in_out=16'h0200 and edge_out[9]=1 six cycles after reset release.
REQ-028 All ten inputs pressed simultaneously -> in_out=16'h03FF and edge_out=10'h3FF on the same cycle.
